// File: rtl/multdiv_unit_if.sv
// Execute-stage multdiv interface: operand/control bundle from the pipeline and
// the registered result/exception/ready bundle back from the responder.
interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    // Handshake: the initiator pulses ctrl_MULT or ctrl_DIV for one cycle with the
    // operands valid on that edge, then waits; the responder answers with a
    // one-cycle data_resultRDY pulse. There is no ready/backpressure path, and
    // data_result/data_exception hold until the next completion.
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic [1:0]       dbg_state;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, dbg_state
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, dbg_state
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (sign-magnitude shift-add) / restoring divide with a
// fixed latency of WIDTH+1 edges from start to the edge that raises data_resultRDY.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opb;
    logic               r_neg;
    logic               r_div_zero;
    logic               r_div_ovf;
    logic [WIDTH-1:0]   r_result;
    logic               r_exception;
    logic               r_rdy;

    logic               w_start;
    logic               w_busy;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_add;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_exc;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_fin_result;
    logic               w_fin_exc;

    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_busy  = (r_state == S_MUL) || (r_state == S_DIV);
    assign w_last  = w_busy && (r_count == CW'(WIDTH));

    assign w_a_neg = bus.data_operandA[WIDTH-1];
    assign w_b_neg = bus.data_operandB[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
    assign w_b_mag = w_b_neg ? (~bus.data_operandB + 1'b1) : bus.data_operandB;

    // Multiply step: conditionally add multiplicand to the high half, then shift
    // the {carry, hi, lo} chain right by one; lo starts as the multiplier.
    assign w_mul_add = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opb}) : {1'b0, r_hi};

    // Divide step: shift {rem, dividend} left, keep the difference if no borrow.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_opb});

    assign w_prod_mag = {r_hi, r_lo};
    assign w_prod     = r_neg ? (~w_prod_mag + 1'b1) : w_prod_mag;
    assign w_mul_exc  = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quot     = r_neg ? (~r_lo + 1'b1) : r_lo;

    always_comb begin
        w_fin_result = '0;
        w_fin_exc    = 1'b0;
        if (r_state == S_MUL) begin
            w_fin_result = w_prod[WIDTH-1:0];
            w_fin_exc    = w_mul_exc;
        end else if (r_div_zero) begin
            w_fin_result = '0;
            w_fin_exc    = 1'b1;
        end else if (r_div_ovf) begin
            w_fin_result = {1'b1, {(WIDTH-1){1'b0}}};
            w_fin_exc    = 1'b1;
        end else begin
            w_fin_result = w_quot;
            w_fin_exc    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A start edge wins over every other transition, aborting any operation.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_IDLE;
            S_MUL:   if (w_last) w_next_state = S_DONE;
            S_DIV:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (bus.ctrl_MULT) begin
            w_next_state = S_MUL;
        end else if (bus.ctrl_DIV) begin
            w_next_state = S_DIV;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opb      <= '0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
        end else if (w_start) begin
            r_count    <= '0;
            r_hi       <= '0;
            r_neg      <= w_a_neg ^ w_b_neg;
            r_div_zero <= (bus.data_operandB == '0);
            r_div_ovf  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                          (bus.data_operandB == {WIDTH{1'b1}});
            if (bus.ctrl_MULT) begin
                r_lo  <= w_b_mag;
                r_opb <= w_a_mag;
            end else begin
                r_lo  <= w_a_mag;
                r_opb <= w_b_mag;
            end
        end else if (w_busy && !w_last) begin
            r_count <= r_count + 1'b1;
            if (r_state == S_MUL) begin
                r_hi <= w_mul_add[WIDTH:1];
                r_lo <= {w_mul_add[0], r_lo[WIDTH-1:1]};
            end else begin
                r_hi <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_div_ok};
            end
        end else begin
            r_count <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_result    <= '0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_rdy <= w_last && !w_start;
            if (w_last && !w_start) begin
                r_result    <= w_fin_result;
                r_exception <= w_fin_exc;
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exception;
    assign bus.data_resultRDY = r_rdy;
    assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed plan cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_multdiv_unit;
    localparam int W   = 32;
    localparam int LAT = 33;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [W:0] exp_q[$];

    multdiv_unit_if #(.WIDTH(W)) mif ();

    multdiv_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: {exception, result} from signed integer arithmetic.
    function automatic logic [W:0] ref_model(input bit is_mult, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, p, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            p = sa * sb;
            return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[W-1:0]};
        end
        if (b == 0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = sa / sb;
        return {1'b0, q[W-1:0]};
    endfunction

    task automatic start_op(input bit is_mult, input bit both, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        @(negedge clock);
        mif.data_operandA = a;
        mif.data_operandB = b;
        mif.ctrl_MULT     = is_mult | both;
        mif.ctrl_DIV      = ~is_mult | both;
        @(posedge clock);
        #1;
        mif.ctrl_MULT     = 1'b0;
        mif.ctrl_DIV      = 1'b0;
        mif.data_operandA = $urandom;
        mif.data_operandB = $urandom;
    endtask

    // Waits exactly LAT edges after a start; checks silence, then pops the scoreboard.
    task automatic expect_done(input string name);
        logic [W:0] exp;
        bit early;
        early = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            @(posedge clock);
            #1;
            if (mif.data_resultRDY !== 1'b0) early = 1'b1;
        end
        n_tests++;
        if (early) begin
            n_fail++;
            $display("FAIL %s early_rdy: got rdy before edge %0d, required none", name, LAT);
        end
        @(posedge clock);
        #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (mif.data_resultRDY !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rdy: got %b required 1", name, mif.data_resultRDY);
        end
        n_tests++;
        if ({mif.data_exception, mif.data_result} !== exp) begin
            n_fail++;
            $display("FAIL %s result: got exc=%b res=%h required exc=%b res=%h", name,
                     mif.data_exception, mif.data_result, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic expect_hold(input string name, input logic [W:0] exp);
        @(posedge clock);
        #1;
        n_tests++;
        if (mif.data_resultRDY !== 1'b0 || {mif.data_exception, mif.data_result} !== exp) begin
            n_fail++;
            $display("FAIL %s hold: got rdy=%b exc=%b res=%h required rdy=0 exc=%b res=%h",
                     name, mif.data_resultRDY, mif.data_exception, mif.data_result,
                     exp[W], exp[W-1:0]);
        end
    endtask

    task automatic run_op(input string name, input bit is_mult, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W:0] exp;
        exp = ref_model(is_mult, a, b);
        exp_q.push_back(exp);
        start_op(is_mult, 1'b0, a, b);
        expect_done(name);
        expect_hold(name, exp);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mif.ctrl_MULT = 1'b0;
        mif.ctrl_DIV = 1'b0;
        mif.data_operandA = '0;
        mif.data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if (mif.data_resultRDY !== 1'b0 || mif.data_exception !== 1'b0 || mif.data_result !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b exc=%b res=%h required all zero",
                     mif.data_resultRDY, mif.data_exception, mif.data_result);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_mult_directed();
        run_op("mul_7x-6", 1'b1, 32'd7, -32'sd6);
        run_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000);
        run_op("mul_min", 1'b1, -32'sd65536, 32'd32768);
    endtask

    task automatic test_div_directed();
        run_op("div_-7/2", 1'b0, -32'sd7, 32'd2);
        run_op("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero", 1'b0, 32'd123, 32'd0);
    endtask

    task automatic test_abort_and_priority();
        start_op(1'b1, 1'b0, 32'd3, 32'd5);
        repeat (9) @(posedge clock);
        exp_q.push_back(ref_model(1'b0, 32'd100, 32'd7));
        start_op(1'b0, 1'b0, 32'd100, 32'd7);
        expect_done("abort_div");
        exp_q.push_back(ref_model(1'b1, 32'd6, 32'd3));
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        expect_done("both_ctrl");
    endtask

    task automatic test_reset_mid();
        bit seen;
        start_op(1'b1, 1'b0, 32'd1000, 32'd1000);
        repeat (20) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (mif.data_resultRDY !== 1'b0 || mif.data_exception !== 1'b0 || mif.data_result !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy=%b exc=%b res=%h required all zero",
                     mif.data_resultRDY, mif.data_exception, mif.data_result);
        end
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (mif.data_resultRDY !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_mid_rdy: got rdy=1 after abort, required 0");
        end
        run_op("post_reset_2x2", 1'b1, 32'd2, 32'd2);
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(ref_model(1'b0, -32'sd1000, 32'd9));
        start_op(1'b0, 1'b0, -32'sd1000, 32'd9);
        expect_done("b2b_first");
        // Next start is sampled on the edge that leaves DONE.
        exp_q.push_back(ref_model(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF));
        start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        expect_done("b2b_second");
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand_%0d", i), bit'($urandom_range(0, 1)), pick_operand(),
                   pick_operand());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_abort_and_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
